// File: rtl/uart_tx_fifo.sv
// 8N1 serial transmitter fed by a small byte FIFO, with a built-in baud counter.
// Frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int unsigned DIV        = 5208,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
    localparam int unsigned BAUD_W = 16;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, count_q, count_d;
    logic              full_q, empty_q, overflow_q;

    state_e            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              tx_q, busy_q, tx_done_q;

    logic              push_c, pop_c, baud_tc_c;
    logic [7:0]        head_c;

    assign baud_tc_c = (baud_q == '0);
    assign head_c    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    // Pop decision uses the pre-edge empty flag; a write while full is always refused.
    assign pop_c     = !empty_q && ((state_q == IDLE) || ((state_q == STOP) && baud_tc_c));
    assign push_c    = wr_en && !full_q;

    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + PTR_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == PTR_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Frame sequencer: every state lasts DIV cycles per bit, tx always from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop_c) begin
                        shift_q <= head_c;
                        baud_q  <= BAUD_RELOAD;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_tc_c) begin
                        baud_q    <= BAUD_RELOAD;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q - BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_tc_c) begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - BAUD_W'(1);
                    end
                end
                STOP: begin
                    // Pulse lands on the final stop-bit cycle.
                    if (baud_q == BAUD_W'(1)) begin
                        tx_done_q <= 1'b1;
                    end
                    if (baud_tc_c) begin
                        if (pop_c) begin
                            shift_q <= head_c;
                            baud_q  <= BAUD_RELOAD;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - BAUD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random stimulus for uart_tx_fifo, checked every cycle against a
// frame-level reference model (byte queue plus position-within-frame arithmetic).
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;

    logic full4, empty4, ovf4, tx4, busy4, done4;
    logic full2, empty2, ovf2, tx2, busy2, done2;

    uart_tx_fifo #(.DIV(4), .DEPTH_LOG2(2)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full4), .empty(empty4), .overflow(ovf4),
        .tx(tx4), .busy(busy4), .tx_done(done4)
    );

    uart_tx_fifo #(.DIV(2), .DEPTH_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full2), .empty(empty2), .overflow(ovf2),
        .tx(tx2), .busy(busy2), .tx_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_asrt = 0;
    int    n_fail = 0;
    int    done_cnt = 0;
    int    cyc = 0;
    bit    sel2 = 0;
    string cur;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_act;
    int         m_t;
    logic [7:0] m_byte;
    bit         m_ovf;
    int         m_div = 4;

    function automatic logic [5:0] obs_vec();
        if (sel2) return {tx2, busy2, done2, full2, empty2, ovf2};
        return {tx4, busy4, done4, full4, empty4, ovf4};
    endfunction

    function automatic logic m_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_t / m_div;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    function automatic logic [5:0] exp_vec();
        logic d;
        d = m_act && (m_t == 10*m_div - 1);
        return {m_tx(), m_act, d, (mq.size() == DEPTH), (mq.size() == 0), m_ovf};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_act = 0;
        m_t   = 0;
        m_ovf = 0;
    endtask

    task automatic model_edge(input logic we, input logic [7:0] wd);
        int         last;
        bit         pre_full, pre_empty, popped, fend;
        logic [7:0] pb;
        last      = 10*m_div - 1;
        pre_full  = (mq.size() == DEPTH);
        pre_empty = (mq.size() == 0);
        fend      = m_act && (m_t == last);
        popped    = 0;
        pb        = 8'h00;
        if ((!m_act || fend) && !pre_empty) begin
            pb = mq.pop_front();
            popped = 1;
        end
        if (we && !pre_full) mq.push_back(wd);
        if (we && pre_full) m_ovf = 1;
        if (popped) begin
            m_act = 1; m_t = 0; m_byte = pb;
        end else if (m_act) begin
            if (fend) m_act = 0;
            else m_t++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_asrt++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, o, e);
        end
    endtask

    task automatic step(input logic we, input logic [7:0] wd);
        logic [5:0] o;
        wr_en   = we;
        wr_data = wd;
        @(posedge clk);
        model_edge(we, wd);
        #1;
        wr_en = 1'b0;
        cyc++;
        o = obs_vec();
        check({cur, "/outs"}, 32'(o), 32'(exp_vec()));
        if (o[3]) done_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        wr_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check({cur, "/rst"}, 32'(obs_vec()), 32'(6'b100_010));
        rst = 1'b1;
    endtask

    int d0;

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        cur = "reset";
        do_reset();
        idle(3);

        // Single byte, latency and full frame
        cur = "single55";
        d0 = done_cnt;
        step(1'b1, 8'h55);
        check("lat_edge1_tx", 32'(tx4), 32'd1);
        step(1'b0, 8'h00);
        check("lat_edge2_tx", 32'(tx4), 32'd0);
        check("lat_edge2_busy", 32'(busy4), 32'd1);
        idle(45);
        check("single55_done", 32'(done_cnt - d0), 32'd1);

        // Four back-to-back frames
        cur = "b2b4";
        d0 = done_cnt;
        step(1'b1, 8'h01); step(1'b1, 8'h80); step(1'b1, 8'hFF); step(1'b1, 8'h00);
        idle(170);
        check("b2b4_done", 32'(done_cnt - d0), 32'd4);
        check("b2b4_idle_busy", 32'(busy4), 32'd0);

        // Fill while busy, fifth write overflows and is never sent
        cur = "ovf5";
        do_reset();
        d0 = done_cnt;
        step(1'b1, 8'h11);
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h21 + i));
        check("ovf5_flag", 32'(ovf4), 32'd1);
        check("ovf5_full", 32'(full4), 32'd1);
        idle(220);
        check("ovf5_sticky", 32'(ovf4), 32'd1);
        check("ovf5_done", 32'(done_cnt - d0), 32'd5);

        // Write on the same edge as the STOP-state pop while full
        cur = "stoppop";
        do_reset();
        step(1'b1, 8'hA1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hB0 + i));
        check("stoppop_full", 32'(full4), 32'd1);
        check("stoppop_ovf0", 32'(ovf4), 32'd0);
        for (int i = 0; i < 100 && !(m_act && m_t == 39); i++) idle(1);
        check("stoppop_reached", 32'(m_act && m_t == 39), 32'd1);
        step(1'b1, 8'hEE);
        check("stoppop_ovf", 32'(ovf4), 32'd1);
        check("stoppop_full_after", 32'(full4), 32'd0);
        idle(200);

        // Asynchronous reset during data bit 3
        cur = "midrst";
        do_reset();
        step(1'b1, 8'hC3); step(1'b1, 8'h3C); step(1'b1, 8'h99);
        for (int i = 0; i < 100 && !(m_act && (m_t / m_div) == 4); i++) idle(1);
        check("midrst_reached", 32'(m_act && (m_t / m_div) == 4), 32'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("midrst_async", 32'(obs_vec()), 32'(6'b100_010));
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(60);
        check("midrst_quiet_tx", 32'(tx4), 32'd1);

        // Random traffic
        cur = "rand";
        do_reset();
        for (int i = 0; i < 1500; i++) step(($urandom_range(0, 99) < 12), 8'($urandom));
        idle(250);

        // Minimum divider
        cur = "div2";
        sel2  = 1;
        m_div = 2;
        do_reset();
        d0 = done_cnt;
        step(1'b1, 8'hA5);
        idle(25);
        check("div2_done", 32'(done_cnt - d0), 32'd1);
        check("div2_idle", 32'(busy2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
